// File: rtl/id00001001_dummy_pkg.sv
// Shared constants for the dummy AIP loopback core: bus map, status bits, FSM states.
package id00001001_pkg;

  localparam logic [31:0] IP_ID_VALUE = 32'h0000_1001;

  localparam logic [4:0] ADDR_MDATAIN   = 5'h00;
  localparam logic [4:0] ADDR_PMDATAIN  = 5'h01;
  localparam logic [4:0] ADDR_MDATAOUT  = 5'h02;
  localparam logic [4:0] ADDR_PMDATAOUT = 5'h03;
  localparam logic [4:0] ADDR_CCONFREG  = 5'h04;
  localparam logic [4:0] ADDR_PCONFREG  = 5'h05;
  localparam logic [4:0] ADDR_STATUS    = 5'h1E;
  localparam logic [4:0] ADDR_IPID      = 5'h1F;

  localparam int STAT_DONE   = 0;
  localparam int STAT_BUSY   = 1;
  localparam int STAT_INT_EN = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COPY,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/id00001001_dummy_if.sv
// AIP host bus: the host (master) drives data/strobes/select, the core (slave) returns read data and interrupt.
interface aip_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  write;
  logic                  read;
  logic                  start;
  logic [4:0]            conf_dbus;
  logic                  int_req;

  modport master (
    output data_in, write, read, start, conf_dbus,
    input  data_out, int_req
  );

  modport slave (
    input  data_in, write, read, start, conf_dbus,
    output data_out, int_req
  );

endinterface

// File: rtl/id00001001_dummy_aip_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable; contents are not reset.
module aip_sdp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/id00001001_dummy.sv
// Dummy AIP accelerator: host fills MEMIN, start copies it word-for-word into MEMOUT,
// then after CONF extra cycles done (and optionally int_req) is raised.
module id00001001_dummy
  import id00001001_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          SIZE_MEM   = 6,
  parameter logic [31:0] IP_ID      = IP_ID_VALUE
) (
  input logic  clk,
  input logic  rst_a,
  input logic  en_s,
  aip_if.slave bus
);

  state_e                state_q, state_d;
  logic [SIZE_MEM-1:0]   pin_q, pin_d;
  logic [SIZE_MEM-1:0]   pout_q, pout_d;
  logic [SIZE_MEM-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0] conf_q, conf_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  int_en_q, int_en_d;
  logic                  int_req_q, int_req_d;
  logic                  out_sel_q, out_sel_d;

  logic                  wr_en, rd_en;
  logic                  memin_we, memout_we, memout_re;
  logic [SIZE_MEM-1:0]   memin_raddr;
  logic [DATA_WIDTH-1:0] memin_rdata, memout_rdata, status_word;

  // A simultaneous write wins over a read; en_s gates every host access.
  assign wr_en = en_s & bus.write;
  assign rd_en = en_s & bus.read & ~bus.write;

  // MEMIN is read one word ahead so word idx is already registered when COPY writes it.
  assign memin_raddr = (state_q == ST_COPY) ? idx_q + 1'b1 : '0;

  aip_sdp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(SIZE_MEM)) memin (
    .clk   (clk),
    .we    (memin_we),
    .waddr (pin_q),
    .wdata (bus.data_in),
    .re    (en_s),
    .raddr (memin_raddr),
    .rdata (memin_rdata)
  );

  aip_sdp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(SIZE_MEM)) memout (
    .clk   (clk),
    .we    (memout_we),
    .waddr (idx_q),
    .wdata (memin_rdata),
    .re    (memout_re),
    .raddr (pout_q),
    .rdata (memout_rdata)
  );

  always_comb begin
    status_word              = '0;
    status_word[STAT_INT_EN] = int_en_q;
    status_word[STAT_BUSY]   = busy_q;
    status_word[STAT_DONE]   = done_q;
  end

  always_comb begin
    state_d   = state_q;
    pin_d     = pin_q;
    pout_d    = pout_q;
    idx_d     = idx_q;
    conf_d    = conf_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    done_d    = done_q;
    busy_d    = busy_q;
    int_en_d  = int_en_q;
    out_sel_d = out_sel_q;
    memin_we  = 1'b0;
    memout_we = 1'b0;
    memout_re = 1'b0;

    if (wr_en) begin
      case (bus.conf_dbus)
        ADDR_MDATAIN: begin
          memin_we = 1'b1;
          pin_d    = pin_q + 1'b1;
        end
        ADDR_PMDATAIN:  pin_d  = bus.data_in[SIZE_MEM-1:0];
        ADDR_PMDATAOUT: pout_d = bus.data_in[SIZE_MEM-1:0];
        ADDR_CCONFREG:  conf_d = bus.data_in;
        ADDR_PCONFREG:  ;
        ADDR_STATUS: begin
          int_en_d = bus.data_in[STAT_INT_EN];
          if (bus.data_in[STAT_DONE]) done_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Register reads land in rdata_q; MEMOUT reads come straight from the RAM's read register.
    if (rd_en) begin
      out_sel_d = 1'b0;
      case (bus.conf_dbus)
        ADDR_MDATAOUT: begin
          memout_re = 1'b1;
          out_sel_d = 1'b1;
          pout_d    = pout_q + 1'b1;
        end
        ADDR_STATUS: rdata_d = status_word;
        ADDR_IPID:   rdata_d = DATA_WIDTH'(IP_ID);
        default:     rdata_d = '0;
      endcase
    end

    if (en_s) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            done_d  = 1'b0;
            busy_d  = 1'b1;
            idx_d   = '0;
            state_d = ST_COPY;
          end
        end
        ST_COPY: begin
          memout_we = 1'b1;
          idx_d     = idx_q + 1'b1;
          if (idx_q == '1) begin
            if (conf_q == '0) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              cnt_d   = conf_q;
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == DATA_WIDTH'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign int_req_d = done_d & int_en_d;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q   <= ST_IDLE;
      pin_q     <= '0;
      pout_q    <= '0;
      idx_q     <= '0;
      conf_q    <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      int_en_q  <= 1'b0;
      int_req_q <= 1'b0;
      out_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pin_q     <= pin_d;
      pout_q    <= pout_d;
      idx_q     <= idx_d;
      conf_q    <= conf_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      int_en_q  <= int_en_d;
      int_req_q <= int_req_d;
      out_sel_q <= out_sel_d;
    end
  end

  assign bus.data_out = out_sel_q ? memout_rdata : rdata_q;
  assign bus.int_req  = int_req_q;

endmodule

// File: tb/tb_id00001001_dummy.sv
// Self-checking bench for the dummy AIP loopback core using a model of MEMIN/MEMOUT and an expected-read scoreboard.
module tb_id00001001_dummy;
  import id00001001_pkg::*;

  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic en_s  = 1'b1;

  aip_if bus ();

  id00001001_dummy dut (
    .clk   (clk),
    .rst_a (rst_a),
    .en_s  (en_s),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_in  [64];
  logic [31:0] model_out [64];
  logic [31:0] wbuf      [64];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];

  task automatic busWrite(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.conf_dbus = addr;
    bus.data_in   = data;
    bus.write     = 1'b1;
    @(negedge clk);
    bus.write     = 1'b0;
  endtask

  task automatic readReg(input logic [4:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.conf_dbus = addr;
    bus.read      = 1'b1;
    @(negedge clk);
    bus.read      = 1'b0;
    data          = bus.data_out;
  endtask

  task automatic getID(output logic [31:0] id);
    readReg(ADDR_IPID, id);
  endtask

  // Burst-writes wbuf[0..n-1] starting at pointer offset and mirrors it into model_in.
  task automatic writeMem(input logic [4:0] addr, input int n, input int offset);
    @(negedge clk);
    bus.conf_dbus = addr + 5'd1;
    bus.data_in   = 32'(offset);
    bus.write     = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.conf_dbus = addr;
      bus.data_in   = wbuf[i];
      model_in[(offset + i) % 64] = wbuf[i];
    end
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic readMem(input logic [4:0] addr, input int n, input int offset);
    @(negedge clk);
    bus.conf_dbus = addr + 5'd1;
    bus.data_in   = 32'(offset);
    bus.write     = 1'b1;
    @(negedge clk);
    bus.write     = 1'b0;
    bus.conf_dbus = addr;
    bus.read      = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got_q.push_back(bus.data_out);
      if (i == n - 1) bus.read = 1'b0;
    end
  endtask

  task automatic start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts negedges after the start pulse until int_req is seen (int_en must be set).
  task automatic waitDone(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.int_req !== 1'b1 && cyc < 2000);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    #1;
    checks++;
    if (bus.data_out !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data_out: got %h expected %h", bus.data_out, 32'h0);
    end
    checks++;
    if (bus.int_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_int_req: got %b expected %b", bus.int_req, 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    getID(v);
    checks++;
    if (v !== 32'h0000_1001) begin
      errors++;
      $display("[TB] FAIL ipid: got %h expected %h", v, 32'h0000_1001);
    end
    readReg(ADDR_STATUS, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_status: got %h expected %h", v, 32'h0);
    end
  endtask

  task automatic test_loopback();
    logic [31:0] e, g;
    for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
    writeMem(ADDR_MDATAIN, 64, 0);
    start();
    model_out = model_in;
    for (int i = 0; i < 64; i++) exp_q.push_back(model_out[i]);
    readMem(ADDR_MDATAOUT, 64, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL loopback_missing: got none expected %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("[TB] FAIL loopback_word: got %h expected %h", g, e);
        end
      end
    end
    got_q.delete();
  endtask

  task automatic test_busy_delay();
    logic [31:0] v;
    int j;
    busWrite(ADDR_CCONFREG, 32'h3E9);
    busWrite(ADDR_STATUS, 32'h0001_0001);
    start();
    readReg(ADDR_STATUS, v);
    j = 2;
    checks++;
    if (v !== 32'h0001_0002) begin
      errors++;
      $display("[TB] FAIL busy_status: got %h expected %h", v, 32'h0001_0002);
    end
    while (bus.int_req !== 1'b1 && j < 1200) begin
      @(negedge clk);
      j++;
    end
    checks++;
    if (j !== 1065) begin
      errors++;
      $display("[TB] FAIL delay_cycles: got %0d expected %0d", j, 1065);
    end
    readReg(ADDR_STATUS, v);
    checks++;
    if (v !== 32'h0001_0001) begin
      errors++;
      $display("[TB] FAIL done_status: got %h expected %h", v, 32'h0001_0001);
    end
    busWrite(ADDR_STATUS, 32'h0001_0001);
    checks++;
    if (bus.int_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL int_req_clear: got %b expected %b", bus.int_req, 1'b0);
    end
    readReg(ADDR_STATUS, v);
    checks++;
    if (v !== 32'h0001_0000) begin
      errors++;
      $display("[TB] FAIL cleared_status: got %h expected %h", v, 32'h0001_0000);
    end
  endtask

  task automatic test_pointer_wrap();
    logic [31:0] e, g;
    int cyc;
    busWrite(ADDR_CCONFREG, 32'h0);
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    writeMem(ADDR_MDATAIN, 4, 62);
    start();
    model_out = model_in;
    waitDone(cyc);
    checks++;
    if (cyc !== 64) begin
      errors++;
      $display("[TB] FAIL wrap_done_cycles: got %0d expected %0d", cyc, 64);
    end
    exp_q.push_back(wbuf[0]);
    exp_q.push_back(wbuf[1]);
    exp_q.push_back(wbuf[2]);
    exp_q.push_back(wbuf[3]);
    exp_q.push_back(model_out[2]);
    readMem(ADDR_MDATAOUT, 5, 62);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL wrap_missing: got none expected %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("[TB] FAIL wrap_word: got %h expected %h", g, e);
        end
      end
    end
    got_q.delete();
  endtask

  task automatic test_enable_hold();
    logic [31:0] v, e, g;
    int cyc;
    getID(v);
    @(negedge clk);
    en_s          = 1'b0;
    bus.conf_dbus = ADDR_MDATAIN;
    bus.data_in   = 32'hDEAD_BEEF;
    bus.write     = 1'b1;
    @(negedge clk);
    bus.conf_dbus = ADDR_PMDATAIN;
    bus.data_in   = 32'd5;
    @(negedge clk);
    bus.conf_dbus = ADDR_CCONFREG;
    bus.data_in   = 32'd7;
    @(negedge clk);
    bus.conf_dbus = ADDR_STATUS;
    bus.data_in   = 32'h0000_0001;
    @(negedge clk);
    bus.write     = 1'b0;
    bus.conf_dbus = ADDR_MDATAOUT;
    bus.read      = 1'b1;
    @(negedge clk);
    bus.read      = 1'b0;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    checks++;
    if (bus.data_out !== 32'h0000_1001) begin
      errors++;
      $display("[TB] FAIL en_hold_data_out: got %h expected %h", bus.data_out, 32'h0000_1001);
    end
    checks++;
    if (bus.int_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL en_hold_int_req: got %b expected %b", bus.int_req, 1'b1);
    end
    en_s = 1'b1;
    readReg(ADDR_STATUS, v);
    checks++;
    if (v !== 32'h0001_0001) begin
      errors++;
      $display("[TB] FAIL en_hold_status: got %h expected %h", v, 32'h0001_0001);
    end
    wbuf[0] = $urandom;
    busWrite(ADDR_MDATAIN, wbuf[0]);
    model_in[2] = wbuf[0];
    start();
    model_out = model_in;
    waitDone(cyc);
    checks++;
    if (cyc !== 64) begin
      errors++;
      $display("[TB] FAIL en_hold_conf: got %0d expected %0d", cyc, 64);
    end
    exp_q.push_back(model_out[2]);
    exp_q.push_back(model_out[3]);
    readMem(ADDR_MDATAOUT, 2, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL en_hold_missing: got none expected %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("[TB] FAIL en_hold_pointer: got %h expected %h", g, e);
        end
      end
    end
    got_q.delete();
  endtask

  task automatic test_reset_mid_copy();
    logic [31:0] v;
    int cyc;
    getID(v);
    start();
    repeat (10) @(negedge clk);
    rst_a = 1'b0;
    #1;
    checks++;
    if (bus.data_out !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_data_out: got %h expected %h", bus.data_out, 32'h0);
    end
    checks++;
    if (bus.int_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_int_req: got %b expected %b", bus.int_req, 1'b0);
    end
    @(negedge clk);
    rst_a = 1'b1;
    readReg(ADDR_STATUS, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_status: got %h expected %h", v, 32'h0);
    end
    busWrite(ADDR_STATUS, 32'h0001_0000);
    start();
    waitDone(cyc);
    checks++;
    if (cyc !== 64) begin
      errors++;
      $display("[TB] FAIL midreset_restart_cycles: got %0d expected %0d", cyc, 64);
    end
    readReg(ADDR_STATUS, v);
    checks++;
    if (v !== 32'h0001_0001) begin
      errors++;
      $display("[TB] FAIL midreset_done_status: got %h expected %h", v, 32'h0001_0001);
    end
  endtask

  initial begin
    bus.data_in   = '0;
    bus.conf_dbus = '0;
    bus.write     = 1'b0;
    bus.read      = 1'b0;
    bus.start     = 1'b0;
    $display("[TB] starting id00001001_dummy bench");
    test_reset();
    test_loopback();
    test_busy_delay();
    test_pointer_wrap();
    test_enable_hold();
    test_reset_mid_copy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id00001001_dummy.md
Name: id00001001_dummy

Overview:
- Dummy accelerator IP (IP ID 0x00001001) with the standard AIP host interface.
- Host loads a 64-word input memory, pulses start, and the core copies input memory to output memory word-for-word.
- After an optional programmable delay the core raises done and int_req; the host then reads the output memory back.
- Used as the loopback reference block for the AIP bus and its bench interface (aip_if).

Parameters:
- DATA_WIDTH, 32, host data bus width.
- SIZE_MEM, 6, log2 of memory depth (64 words each for MEMIN and MEMOUT).
- IP_ID, 32'h00001001, value returned at the IPID address.

Ports:
- clk  in  1  system clock; rising edge active.
- rst_a  in  1  asynchronous active-low reset.
- en_s  in  1  synchronous enable; when 0, write/read/start are ignored and all state holds.
- data_in  in  32  host write data.
- data_out  out  32  host read data, registered.
- write  in  1  write strobe; one access per cycle while high.
- read  in  1  read strobe; one access per cycle while high.
- start  in  1  start pulse.
- conf_dbus  in  5  register/memory select.
- int_req  out  1  interrupt request, level.

Behaviour:
- Reset is asynchronous on rst_a=0 and clears the following to 0:
  - data_out, int_req, both pointers, CONF, done, busy, int_en, delay counter, copy index.
- RAM contents are not reset.
- conf_dbus map:
  - 0x00 MDATAIN: write data to MEMIN[pin]; pin++.
  - 0x01 PMDATAIN: write sets pin.
  - 0x02 MDATAOUT: read MEMOUT[pout]; pout++.
  - 0x03 PMDATAOUT: write sets pout.
  - 0x04 CCONFREG: write sets CONF delay.
  - 0x05 PCONFREG: write accepted and ignored (single config register).
  - 0x1E STATUS: read gives {15'b0, int_en (bit 16), 14'b0, busy (bit 1), done (bit 0)}. Write: bit 16 loads int_en; bit 0 = 1 clears done.
  - 0x1F IPID: read returns IP_ID.
  - Unmapped addresses: reads return 0, writes are ignored.
- Pointers are SIZE_MEM bits wide and wrap 63 -> 0. Pointer writes use data_in[SIZE_MEM-1:0].
- Read latency is 1 clock: data_out updates on the edge where read=1 and holds otherwise.
- If read and write are both high in the same cycle, the write is performed and the read is ignored.
- FSM IDLE -> COPY -> WAIT -> DONE:
  - IDLE: start=1 (with en_s=1) clears done, sets busy, idx=0, goes to COPY.
  - COPY: each cycle MEMOUT[idx] <= MEMIN[idx], idx++. Word k is written at the k+1-th edge after start. After word 63, load the delay counter from CONF and go to WAIT.
  - WAIT: decrement the counter; when it reaches 0 (CONF=0 means zero cycles), set done, clear busy, go to IDLE.
  - Total start-to-done is 64 + CONF cycles.
- Because copying is ascending and one word per clock, host reads of MEMOUT word k issued after the copy of word k return correct data even while busy.
- start while busy is ignored.
- int_req = done & int_en (registered).
- Host writes to MEMIN during COPY are allowed; the copied value is undefined for that word.
- Reset mid-operation aborts the copy and returns the FSM to IDLE.

Decomposition:
- Package id00001001_pkg holds:
  - conf_dbus address constants;
  - IP_ID;
  - STATUS bit indices;
  - the FSM state enum.
- One sub-module, aip_sdp_ram: simple dual-port RAM with 1 write port and 1 registered read port, 2**SIZE_MEM x DATA_WIDTH.
  - Instance MEMIN: written by the host, read by the copy engine.
  - Instance MEMOUT: written by the copy engine, read by the host.
- The bench interface aip_if drives data_in, conf_dbus, read, write and start, and samples data_out and int_req. It provides these tasks:
  - getID: read 0x1F.
  - writeMem(addr, data, n, offset): set the pointer at addr+1, then burst-write at addr.
  - readMem: the same pattern for reads.
  - start: 1-cycle start pulse.

Test Plan:
- Reset, then getID -> 0x00001001; status reads 0x00000000.
- Write 64 random words via 0x00 from pointer 0, start, read 64 words via 0x02 from pointer 0 -> every word equal (loopback), with no wait for done.
- Write CONF=0x3E9, start -> busy=1 for 64+1001 cycles, then done=1; with int_en=1, int_req rises on the same edge; write STATUS bit 0 -> done and int_req go to 0.
- Pointer wrap: set pin=62, write 4 words, copy -> MEMOUT[62], [63], [0], [1] hold them in order.
- en_s=0 while pulsing write, read and start -> no memory, pointer or state change, and data_out holds.
- Assert rst_a=0 mid-COPY -> outputs 0 and FSM IDLE; after release, a new start completes in 64 cycles.
